// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: serial adder processing one 4-bit carry-lookahead
// slice per clock. Operands are captured on acceptance, slices are added
// LSB first with the inter-slice carry held in a register, and the result
// is presented with a valid/ready handshake.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             live;
    logic             accept;
    logic             last;

    // Current slice operands and carry-lookahead terms
    logic [3:0]       sa;
    logic [3:0]       sb;
    logic [3:0]       sg;
    logic [3:0]       sp;
    logic [3:0]       ss;
    logic [4:0]       sc;

    assign in_ready  = (state == IDLE) && live;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_ready && in_valid;
    assign last      = (idx == LAST);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept)    state_nx = RUN;
            RUN:  if (last)      state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    // Select nibble idx of the captured operands
    always_comb begin
        sa = '0;
        sb = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) begin
                sa = a_q[4*i +: 4];
                sb = b_q[4*i +: 4];
            end
        end
    end

    // 4-bit carry-lookahead slice; every carry is expanded from G, P and the
    // registered slice carry-in so no carry ripples within the slice
    always_comb begin
        sg    = sa & sb;
        sp    = sa ^ sb;
        sc[0] = carry;
        sc[1] = sg[0] | (sp[0] & carry);
        sc[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & carry);
        sc[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
              | (sp[2] & sp[1] & sp[0] & carry);
        sc[4] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
              | (sp[3] & sp[2] & sp[1] & sg[0])
              | (sp[3] & sp[2] & sp[1] & sp[0] & carry);
        ss    = sp ^ sc[3:0];
    end

    // Operand capture, per-slice sum write-back and final flag registration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum_q <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < NIB; i++) begin
                        if (idx == IW'(i)) begin
                            sum_q[4*i +: 4] <= ss;
                        end
                    end
                    carry <= sc[4];
                    idx   <= last ? '0 : idx + IW'(1);
                    if (last) begin
                        cout_q <= sc[4];
                        ovf_q  <= sc[3] ^ sc[4];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
